dds_ram_sched: RTL and testbench
================================

# dds_ram_sched

Scheduler that shares the single-port 1024×32 waveform RAM (`singel_port_ram`: clka/wea/addra/dina/douta) between a host table-load write port and the DDS read stream. A phase accumulator generates the read address every cycle while DDS is enabled. Host writes are accepted freely when DDS is idle and rate-limited by a gap counter when running. The block owns all RAM control pins and returns read data to the DDS output with a matching valid strobe.

## Interface
- ADDR_W, 10, RAM address width (1024 words)
- DATA_W, 32, RAM data width
- PHASE_W, 32, phase accumulator width; RAM address = phase[PHASE_W-1 -: ADDR_W]
- RD_LAT, 1, RAM read latency in clocks from addra registered to douta valid (≥1)
- WR_GAP, 8, minimum DDS read cycles between two granted writes while running (≥1)

- clk  in  1  single clock; also drives RAM clka
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready
- wr_addr  in  ADDR_W  host write address
- wr_data  in  DATA_W  host write data
- dds_en  in  1  1 = run DDS read stream
- phase_clr  in  1  synchronous clear of phase accumulator
- fword  in  PHASE_W  frequency tuning word, sampled on each read issue
- dds_valid  out  1  dds_data holds a table sample
- dds_data  out  DATA_W  sample = ram_douta passed through
- ram_wea  out  1  to RAM wea, registered
- ram_addra  out  ADDR_W  to RAM addra, registered
- ram_dina  out  DATA_W  to RAM dina, registered
- ram_douta  in  DATA_W  from RAM douta
- busy  out  1  1 while state = RUN or reads in flight

## Operation
- States: IDLE (dds_en=0), RUN (dds_en=1). Transition evaluated each cycle from dds_en; no other states.
- Per-cycle slot decision (exactly one of: write, read, nop):
  - IDLE: wr_ready=1; handshake → write slot; else nop.
  - RUN: wr_ready = (gap_cnt == WR_GAP); handshake → write slot; else read slot.
- Write slot: register ram_wea=1, ram_addra=wr_addr, ram_dina=wr_data; gap_cnt←0; phase unchanged.
- Read slot: register ram_wea=0, ram_addra=phase[PHASE_W-1 -: ADDR_W]; phase←phase+fword (mod 2^PHASE_W, carry discarded); gap_cnt←min(gap_cnt+1, WR_GAP); push 1 into valid pipe.
- Nop slot: ram_wea=0, ram_addra/ram_dina hold, phase holds, push 0 into valid pipe.
- gap_cnt width ⌈log2(WR_GAP+1)⌉; does not change in IDLE.
- phase_clr: phase←0 next cycle; if same cycle is a read slot, the issued address uses the pre-clear phase, and clear takes priority over the increment.
- Valid pipe: RD_LAT+1 stage shift register; dds_valid = last stage; dds_data = ram_douta combinationally.
- dds_en falling: no new reads from that cycle; in-flight reads still emit dds_valid; busy drops when pipe empty.
- Write during IDLE to address X followed by read of X returns new data (RAM write-first irrelevant: read is always a later slot).

## Timing
- Reset values: ram_wea=0, ram_addra=0, ram_dina=0, phase=0, gap_cnt=WR_GAP, valid pipe=0, dds_valid=0, busy=0, state=IDLE. wr_ready=0 during rst.
- rst asserted mid-operation: all above values next edge; in-flight reads discarded (no dds_valid).
- Write: handshake in cycle t → ram_wea=1 in cycle t+1 → RAM updated at edge ending t+1.
- Read: slot in cycle t → ram_addra in t+1 → douta and dds_valid in cycle t+1+RD_LAT.
- RUN with wr_valid held: writes granted every WR_GAP+1 cycles (WR_GAP reads between); first write after reset or after a long idle gap is granted immediately.
- Sustained DDS: one sample per cycle except write slots, which create a one-cycle dds_valid hole.

## Test plan
- Reset then IDLE load: write addr 0..19 with data i*i back-to-back → wr_ready=1 every cycle, ram_wea=1 for 20 consecutive cycles, RAM word 5 = 25.
- RUN with fword=2^22 (step 1 address), phase_clr pulse: dds_data sequence 0,1,4,9,… starting 1+RD_LAT cycles after first read slot, dds_valid continuous.
- Wrap-around: fword=2^22, run 1030 cycles → address 1023 followed by 0, no valid gap.
- Contention: RUN, wr_valid held, WR_GAP=8 → grants exactly every 9th cycle, dds_valid low one cycle per grant, phase skip count 0.
- dds_en dropped mid-stream → reads stop same cycle, exactly RD_LAT+1 pending dds_valid pulses drain, busy falls after last.
- rst asserted with reads in flight → dds_valid=0 next cycle, phase=0, gap_cnt=WR_GAP, ram_wea=0.

Source files
------------

// File: rtl/dds_ram_sched.sv
// dds_ram_sched
// Shares one single-port waveform RAM between a host table-load write
// port and a DDS read stream driven by a phase accumulator.
//
// Ports:
//   clk, rst             clock (also the RAM clock) and synchronous active-high reset
//   wr_valid/wr_ready    host write handshake; wr_addr/wr_data carry the write
//   dds_en               1 = run the DDS read stream
//   phase_clr            synchronous clear of the phase accumulator
//   fword                frequency tuning word, added on every read issue
//   dds_valid/dds_data   table sample output (dds_data = ram_douta)
//   ram_wea/ram_addra/ram_dina   registered RAM control, ram_douta RAM read data
//   busy                 high while running or while reads are still in flight
module dds_ram_sched #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int PHASE_W = 32,
    parameter int RD_LAT  = 1,
    parameter int WR_GAP  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               dds_en,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] fword,
    output logic               dds_valid,
    output logic [DATA_W-1:0]  dds_data,
    output logic               ram_wea,
    output logic [ADDR_W-1:0]  ram_addra,
    output logic [DATA_W-1:0]  ram_dina,
    input  logic [DATA_W-1:0]  ram_douta,
    output logic               busy
);

    localparam int GAP_W = $clog2(WR_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(WR_GAP);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {SLOT_NOP, SLOT_WR, SLOT_RD} slot_t;

    state_t             state;
    state_t             next_state;
    slot_t              slot;
    logic [PHASE_W-1:0] phase;
    logic [GAP_W-1:0]   gap_cnt;
    logic [RD_LAT:0]    vpipe;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: the mode follows dds_en directly
    always_comb begin
        next_state = dds_en ? RUN : IDLE;
    end

    // Output / slot decision. The slot uses next_state rather than the
    // registered state so that reads stop in the very cycle dds_en drops.
    always_comb begin
        wr_ready = 1'b0;
        slot     = SLOT_NOP;
        if (!rst) begin
            if (next_state == IDLE) begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    slot = SLOT_WR;
                end
            end else begin
                wr_ready = (gap_cnt == GAP_MAX);
                slot     = (wr_valid && wr_ready) ? SLOT_WR : SLOT_RD;
            end
        end
    end

    // RAM control, phase accumulator, write-gap counter, valid pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
            phase     <= '0;
            gap_cnt   <= GAP_MAX;
            vpipe     <= '0;
        end else begin
            vpipe <= {vpipe[RD_LAT-1:0], (slot == SLOT_RD)};
            case (slot)
                SLOT_WR: begin
                    ram_wea   <= 1'b1;
                    ram_addra <= wr_addr;
                    ram_dina  <= wr_data;
                    // Gap only counts while running; idle table loads leave
                    // it saturated so the first write in RUN is immediate.
                    if (next_state == RUN) begin
                        gap_cnt <= '0;
                    end
                end
                SLOT_RD: begin
                    ram_wea   <= 1'b0;
                    ram_addra <= phase[PHASE_W-1 -: ADDR_W];
                    phase     <= phase + fword;
                    gap_cnt   <= (gap_cnt == GAP_MAX) ? GAP_MAX : gap_cnt + GAP_W'(1);
                end
                default: begin
                    ram_wea <= 1'b0;
                end
            endcase
            // Clear overrides the increment; a read issued this cycle has
            // already taken its address from the pre-clear phase.
            if (phase_clr) begin
                phase <= '0;
            end
        end
    end

    assign dds_valid = vpipe[RD_LAT];
    assign dds_data  = ram_douta;
    assign busy      = !rst && ((state == RUN) || (next_state == RUN) || (|vpipe));

endmodule

// File: tb/tb_dds_ram_sched.sv
// tb_dds_ram_sched
// Directed bench for dds_ram_sched with a 1024x32 single-port RAM model
// (one clock read latency). Table is preloaded with 0xDEAD0000|addr, then
// words 0..19 are overwritten with addr*addr through the DUT.
module tb_dds_ram_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        dds_en;
    logic        phase_clr;
    logic [31:0] fword;
    logic        dds_valid;
    logic [31:0] dds_data;
    logic        ram_wea;
    logic [9:0]  ram_addra;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta;
    logic        busy;

    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dds_ram_sched #(
        .ADDR_W (10),
        .DATA_W (32),
        .PHASE_W(32),
        .RD_LAT (1),
        .WR_GAP (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dds_en   (dds_en),
        .phase_clr(phase_clr),
        .fword    (fword),
        .dds_valid(dds_valid),
        .dds_data (dds_data),
        .ram_wea  (ram_wea),
        .ram_addra(ram_addra),
        .ram_dina (ram_dina),
        .ram_douta(ram_douta),
        .busy     (busy)
    );

    // Single-port RAM model, read latency 1
    always @(posedge clk) begin
        if (preload) begin
            for (int unsigned a = 0; a < 1024; a++) begin
                mem[a] <= 32'hDEAD_0000 | a;
            end
        end else begin
            if (ram_wea) begin
                mem[ram_addra] <= ram_dina;
            end
            ram_douta <= ram_wea ? ram_dina : mem[ram_addra];
        end
    end

    function automatic logic [31:0] tbl(input int unsigned a);
        if (a < 20) return a * a;
        return 32'hDEAD_0000 | a;
    endfunction

    // Address of the read issued in contention slot s (s>=1, not a write slot):
    // reads resume at 16 and one write slot falls every 9 slots starting at 0.
    function automatic int unsigned cont_addr(input int unsigned s);
        return 16 + s - (s + 8) / 9;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        dds_en = 1'b0; phase_clr = 1'b0; fword = '0;

        // Reset
        step();
        settle(); chk("rst_wr_ready", wr_ready, 0);
        step();
        rst = 1'b0; preload = 1'b0;
        settle();
        chk("rst_wea", ram_wea, 0);
        chk("rst_addra", ram_addra, 0);
        chk("rst_dina", ram_dina, 0);
        chk("rst_valid", dds_valid, 0);
        chk("rst_busy", busy, 0);
        chk("idle_wr_ready", wr_ready, 1);
        step();

        // IDLE table load, back-to-back
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1; wr_addr = 10'(i); wr_data = 32'(i * i);
            settle();
            chk("load_ready", wr_ready, 1);
            if (i > 0) begin
                chk("load_wea", ram_wea, 1);
                chk("load_addra", ram_addra, i - 1);
                chk("load_dina", ram_dina, (i - 1) * (i - 1));
            end
            step();
        end
        wr_valid = 1'b0; phase_clr = 1'b1;
        settle();
        chk("load_wea_last", ram_wea, 1);
        chk("load_addra_last", ram_addra, 19);
        chk("load_dina_last", ram_dina, 361);
        step();
        phase_clr = 1'b0;
        settle();
        chk("load_wea_end", ram_wea, 0);
        chk("load_addra_hold", ram_addra, 19);
        chk("ram_word5", mem[5], 25);
        chk("idle_valid", dds_valid, 0);
        step();

        // Continuous stream, one address per cycle, through the wrap
        for (int j = 0; j < 1040; j++) begin
            dds_en = 1'b1; fword = 32'h0040_0000;
            settle();
            if (j == 0) chk("run_first_ready", wr_ready, 1);
            chk("run_busy", busy, 1);
            if (j >= 1) chk("run_addra", ram_addra, (j - 1) % 1024);
            if (j >= 2) begin
                chk("run_valid", dds_valid, 1);
                chk("run_data", dds_data, tbl((j - 2) % 1024));
            end else begin
                chk("run_valid_lat", dds_valid, 0);
            end
            step();
        end

        // Contention: write request held, grants every 9th cycle
        for (int i = 0; i < 36; i++) begin
            wr_valid = 1'b1; wr_addr = 10'd1000; wr_data = 32'hC0DE_0000 | i;
            settle();
            chk("cont_ready", wr_ready, (i % 9) == 0);
            if (i == 0) begin
                chk("cont_wea0", ram_wea, 0);
                chk("cont_addra0", ram_addra, 15);
            end else if ((i - 1) % 9 == 0) begin
                chk("cont_wea", ram_wea, 1);
                chk("cont_waddr", ram_addra, 1000);
                chk("cont_wdata", ram_dina, 32'hC0DE_0000 | (i - 1));
            end else begin
                chk("cont_wea_rd", ram_wea, 0);
                chk("cont_raddr", ram_addra, cont_addr(i - 1));
            end
            if (i < 2) begin
                chk("cont_valid_pre", dds_valid, 1);
                chk("cont_data_pre", dds_data, tbl(14 + i));
            end else if ((i - 2) % 9 == 0) begin
                chk("cont_hole", dds_valid, 0);
            end else begin
                chk("cont_valid", dds_valid, 1);
                chk("cont_data", dds_data, tbl(cont_addr(i - 2)));
            end
            step();
        end

        // dds_en drop: two pending samples drain, busy follows
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b0; dds_en = 1'b0;
            settle();
            chk("drop_valid", dds_valid, k < 2);
            chk("drop_busy", busy, k < 2);
            chk("drop_wea", ram_wea, 0);
            chk("drop_addra", ram_addra, 47);
            if (k < 2) chk("drop_data", dds_data, tbl(46 + k));
            step();
        end

        // phase_clr on a read slot: pre-clear address issued, then restart at 0
        dds_en = 1'b1; phase_clr = 1'b1;
        settle(); chk("clr_ready", wr_ready, 1);
        step();
        phase_clr = 1'b0;
        settle(); chk("clr_addra_pre", ram_addra, 48);
        step();
        settle();
        chk("clr_addra0", ram_addra, 0);
        chk("clr_valid", dds_valid, 1);
        chk("clr_data_pre", dds_data, tbl(48));
        step();
        settle();
        chk("clr_addra1", ram_addra, 1);
        chk("clr_data0", dds_data, 0);
        step();
        settle();
        chk("clr_addra2", ram_addra, 2);
        chk("clr_data1", dds_data, 1);
        step();

        // Reset with reads in flight
        rst = 1'b1;
        settle(); chk("mid_rst_ready", wr_ready, 0);
        step();
        rst = 1'b0; dds_en = 1'b0;
        settle();
        chk("mid_rst_valid", dds_valid, 0);
        chk("mid_rst_wea", ram_wea, 0);
        chk("mid_rst_addra", ram_addra, 0);
        chk("mid_rst_dina", ram_dina, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready_idle", wr_ready, 1);
        step();
        dds_en = 1'b1; wr_valid = 1'b1; wr_addr = 10'd7; wr_data = 32'h1234_5678;
        settle();
        chk("post_rst_gap_ready", wr_ready, 1);
        chk("post_rst_busy", busy, 1);
        step();
        wr_valid = 1'b0;
        settle();
        chk("post_rst_wea", ram_wea, 1);
        chk("post_rst_waddr", ram_addra, 7);
        chk("post_rst_wdata", ram_dina, 32'h1234_5678);
        chk("post_rst_valid0", dds_valid, 0);
        step();
        settle();
        chk("post_rst_wea_rd", ram_wea, 0);
        chk("post_rst_phase0", ram_addra, 0);
        chk("post_rst_hole", dds_valid, 0);
        step();
        settle();
        chk("post_rst_valid", dds_valid, 1);
        chk("post_rst_data0", dds_data, 0);
        chk("post_rst_addra1", ram_addra, 1);
        step();
        dds_en = 1'b0;
        settle();
        chk("post_rst_data1", dds_data, 1);
        step();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
